wishbone_burst_manager: RTL and testbench
=========================================

Name: wishbone_burst_manager

Overview:
Parametrised successor to the single-word Wishbone manager. Accepts one CPU-side read or write command of 1..MAX_BURST beats. Runs it as a single classic Wishbone cycle: CYC held for the whole burst, STB per beat, address incremented by SEL_WIDTH bytes per beat. Sits between the CPU/test logic and the wishbone_arbitrator manager port, and adds per-beat read/write data handshakes, a burst length, and an optional ACK timeout.

Parameters:
DATA_WIDTH, 32, Wishbone data width in bits (multiple of 8)
ADDR_WIDTH, 32, Wishbone byte-address width
SEL_WIDTH, DATA_WIDTH/8, byte-select width; also the address increment per beat
MAX_BURST, 16, maximum beats per command (>=1)
LEN_WIDTH, $clog2(MAX_BURST+1), width of LEN_I
TIMEOUT_CYCLES, 255, cycles STB may wait for ACK before abort (only used with WBM_TIMEOUT_EN)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
WRITE_I  in  1  start write command (sampled in IDLE)
READ_I  in  1  start read command (sampled in IDLE)
ADR_I  in  ADDR_WIDTH  start byte address
LEN_I  in  LEN_WIDTH  beat count
SEL_I  in  SEL_WIDTH  byte selects, applied to all beats
CPU_DAT_I  in  DATA_WIDTH  write data for current beat
CPU_DAT_ACK_O  out  1  write beat data consumed this edge
CPU_DAT_O  out  DATA_WIDTH  read data of last acked beat
CPU_DAT_VALID_O  out  1  one-cycle pulse: CPU_DAT_O holds a new beat
BUSY_O  out  1  command in progress
ERR_O  out  1  one-cycle pulse: command aborted by timeout
DAT_I  in  DATA_WIDTH  Wishbone read data
ACK_I  in  1  Wishbone acknowledge
ADR_O  out  ADDR_WIDTH  Wishbone address
DAT_O  out  DATA_WIDTH  Wishbone write data
SEL_O  out  SEL_WIDTH  Wishbone byte selects
WE_O  out  1  Wishbone write enable
STB_O  out  1  Wishbone strobe
CYC_O  out  1  Wishbone cycle

Behaviour:
- Reset: every output is 0. State is IDLE. Beat and timeout counters are 0. Reset takes effect immediately when nRST falls, including mid-burst; the bus is released that instant.
- States:
  - IDLE: outputs idle.
  - BUS: CYC_O=STB_O=1.
  - DONE: one cycle, CYC_O=STB_O=0, BUSY_O=0; then returns to IDLE.
- Command start, at a posedge in IDLE:
  - Exactly one of READ_I or WRITE_I high: go to BUS.
  - Both high: command ignored, stay IDLE.
  - On entry to BUS, register: ADR_O<=ADR_I, SEL_O<=SEL_I, WE_O<=WRITE_I, beats<=LEN_I, DAT_O<=CPU_DAT_I (write only).
  - BUSY_O, CYC_O and STB_O rise the cycle after the request edge.
- Beat count rules: LEN_I=0 is treated as 1 beat. LEN_I>MAX_BURST is clamped to MAX_BURST.
- Requests while not IDLE are ignored, with no queueing.
- A beat completes on a posedge in BUS with ACK_I=1. ACK_I in any other state is ignored.
- On each non-final beat:
  - ADR_O += SEL_WIDTH, wrapping modulo 2^ADDR_WIDTH.
  - STB_O stays high, so back-to-back beats are possible (1 cycle/beat with zero-wait ACK).
- Write beats:
  - CPU_DAT_ACK_O = combinational (BUS & WE_O & ACK_I & not final beat).
  - On that edge DAT_O<=CPU_DAT_I, which is the next beat's data. The CPU must update CPU_DAT_I before the following edge.
  - Beat-0 data is captured at the request edge.
- Read beats:
  - On each ACK edge, CPU_DAT_O<=DAT_I and CPU_DAT_VALID_O pulses high for the next cycle.
  - CPU_DAT_O holds its value until the next beat.
- Final beat ACK:
  - Go to DONE.
  - CYC_O, STB_O and WE_O drop at that edge. BUSY_O drops at the same edge.
  - A new command is accepted no earlier than the edge after DONE, which gives a 1-cycle minimum bus-idle gap between commands.
- The beat counter never underflows. Reaching a count of 1 on ACK ends the command.

Optional Feature:
WBM_TIMEOUT_EN:
- Defined:
  - A counter clears on entering BUS and on each ACK, and increments every BUS cycle without ACK.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE: ERR_O pulses for 1 cycle, CYC_O/STB_O/WE_O drop, BUSY_O drops, and remaining beats are discarded.
  - CPU_DAT_VALID_O is not pulsed for the aborted beat.
- Undefined: no counter exists, ERR_O is tied 0, and the manager waits indefinitely for ACK.

Test Plan:
- Reset mid-burst: start a read with LEN_I=4, assert nRST=0 after beat 1 -> all outputs 0 asynchronously; an 8-beat read after release completes normally.
- Single write: ADR_I=0x31000000, LEN_I=1, CPU_DAT_I=12, ACK after 2 cycles -> ADR_O=0x31000000, DAT_O=12, WE_O=1, SEL_O=0xF; BUSY_O low the edge after ACK; readback (READ_I, LEN_I=1) -> CPU_DAT_O=12 with one CPU_DAT_VALID_O pulse.
- 4-beat read, zero-wait ACK, DAT_I=0xA0..0xA3 -> ADR_O steps 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 VALID pulses with data 0xA0..0xA3; CYC_O high for exactly 4 cycles.
- 3-beat write with 1-wait ACKs, CPU updating data on each CPU_DAT_ACK_O -> DAT_O 0x11, 0x22, 0x33 per beat; exactly 2 CPU_DAT_ACK_O pulses.
- Boundaries, each a separate command:
  - LEN_I=0 -> 1 beat.
  - LEN_I=31 with MAX_BURST=16 -> 16 beats.
  - ADR_I=0xFFFFFFFC, LEN_I=2 -> second address 0x00000000.
  - READ_I=WRITE_I=1 -> no CYC_O.
  - READ_I pulsed while BUSY_O -> ignored.
- WBM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ACK never asserted -> CYC_O falls 8 cycles after STB_O rises, one ERR_O pulse, no VALID pulse; without the macro, CYC_O stays high after 100 cycles.

Source files
------------

// File: rtl/wishbone_burst_manager.sv
// Wishbone burst manager: runs one CPU read or write command of 1..MAX_BURST
// beats as a single classic Wishbone cycle (CYC held, STB per beat, address
// stepping by SEL_WIDTH bytes).
// Optional feature: define WBM_TIMEOUT_EN to abort a beat whose ACK does not
// arrive within TIMEOUT_CYCLES cycles (ERR_O pulses); otherwise ERR_O is 0.
module wishbone_burst_manager #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_BURST      = 16,
    parameter int LEN_WIDTH      = $clog2(MAX_BURST + 1),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  WRITE_I,
    input  logic                  READ_I,
    input  logic [ADDR_WIDTH-1:0] ADR_I,
    input  logic [LEN_WIDTH-1:0]  LEN_I,
    input  logic [SEL_WIDTH-1:0]  SEL_I,
    input  logic [DATA_WIDTH-1:0] CPU_DAT_I,
    output logic                  CPU_DAT_ACK_O,
    output logic [DATA_WIDTH-1:0] CPU_DAT_O,
    output logic                  CPU_DAT_VALID_O,
    output logic                  BUSY_O,
    output logic                  ERR_O,
    input  logic [DATA_WIDTH-1:0] DAT_I,
    input  logic                  ACK_I,
    output logic [ADDR_WIDTH-1:0] ADR_O,
    output logic [DATA_WIDTH-1:0] DAT_O,
    output logic [SEL_WIDTH-1:0]  SEL_O,
    output logic                  WE_O,
    output logic                  STB_O,
    output logic                  CYC_O
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] beats;
    logic                 start;
    logic                 beat_ack;
    logic                 last_beat;
    logic                 timeout;

    // A zero length still means one beat; oversize requests saturate.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (len == '0)
            return LEN_WIDTH'(1);
        else if (len > LEN_WIDTH'(MAX_BURST))
            return LEN_WIDTH'(MAX_BURST);
        else
            return len;
    endfunction

    assign start     = (state == IDLE) && (READ_I ^ WRITE_I);
    assign beat_ack  = (state == BUS) && ACK_I;
    assign last_beat = (beats == LEN_WIDTH'(1));

    assign CYC_O  = (state == BUS);
    assign STB_O  = (state == BUS);
    assign BUSY_O = (state == BUS);

    // Next write word is consumed on every non-final acked write beat.
    assign CPU_DAT_ACK_O = beat_ack && WE_O && !last_beat;

`ifdef WBM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Abort on the edge where the wait count would reach TIMEOUT_CYCLES.
    assign timeout = (state == BUS) && !ACK_I &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign ERR_O   = err_q;

    // ACK wait counter and one-cycle error pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state == BUS && !ACK_I && !timeout)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            else
                tmo_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign ERR_O   = 1'b0;
`endif

    // Command state machine, beat counter and write-enable.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            beats <= '0;
            WE_O  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUS;
                        beats <= clamp_len(LEN_I);
                        WE_O  <= WRITE_I;
                    end
                end
                BUS: begin
                    if (ACK_I) begin
                        if (last_beat) begin
                            state <= DONE;
                            beats <= '0;
                            WE_O  <= 1'b0;
                        end else begin
                            beats <= beats - LEN_WIDTH'(1);
                        end
                    end else if (timeout) begin
                        state <= DONE;
                        beats <= '0;
                        WE_O  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus address/select/write data and CPU-side read data registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ADR_O           <= '0;
            SEL_O           <= '0;
            DAT_O           <= '0;
            CPU_DAT_O       <= '0;
            CPU_DAT_VALID_O <= 1'b0;
        end else begin
            CPU_DAT_VALID_O <= 1'b0;
            if (start) begin
                ADR_O <= ADR_I;
                SEL_O <= SEL_I;
                if (WRITE_I)
                    DAT_O <= CPU_DAT_I;
            end
            if (beat_ack) begin
                if (!WE_O) begin
                    CPU_DAT_O       <= DAT_I;
                    CPU_DAT_VALID_O <= 1'b1;
                end
                if (!last_beat) begin
                    ADR_O <= ADR_O + ADDR_WIDTH'(SEL_WIDTH);
                    if (WE_O)
                        DAT_O <= CPU_DAT_I;
                end
            end
        end
    end

endmodule

// File: tb/tb_wishbone_burst_manager.sv
// Directed self-checking bench for wishbone_burst_manager.
module tb_wishbone_burst_manager;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        WRITE_I, READ_I;
    logic [31:0] ADR_I;
    logic [4:0]  LEN_I;
    logic [3:0]  SEL_I;
    logic [31:0] CPU_DAT_I;
    logic        CPU_DAT_ACK_O;
    logic [31:0] CPU_DAT_O;
    logic        CPU_DAT_VALID_O;
    logic        BUSY_O, ERR_O;
    logic [31:0] DAT_I;
    logic        ACK_I;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O, STB_O, CYC_O;

    int checks = 0;
    int errors = 0;
    int acks;

    wishbone_burst_manager #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .nRST(nRST), .WRITE_I(WRITE_I), .READ_I(READ_I),
        .ADR_I(ADR_I), .LEN_I(LEN_I), .SEL_I(SEL_I), .CPU_DAT_I(CPU_DAT_I),
        .CPU_DAT_ACK_O(CPU_DAT_ACK_O), .CPU_DAT_O(CPU_DAT_O),
        .CPU_DAT_VALID_O(CPU_DAT_VALID_O), .BUSY_O(BUSY_O), .ERR_O(ERR_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .SEL_O(SEL_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Zero-wait read burst; slave returns 0xA0+i on beat i.
    task automatic read_burst(input logic [31:0] addr, input logic [4:0] len_in, input int beats);
        int          cyc_n;
        logic [31:0] exp_a;
        ADR_I = addr; LEN_I = len_in; SEL_I = 4'hF; READ_I = 1'b1;
        step();
        READ_I = 1'b0;
        chk("rd_busy", BUSY_O, 1);
        chk("rd_we", WE_O, 0);
        ACK_I = 1'b1;
        cyc_n = 0;
        for (int i = 0; i < beats; i++) begin
            exp_a = addr + 32'(4 * i);
            chk("rd_adr", ADR_O, exp_a);
            chk("rd_stb", STB_O, 1);
            if (CYC_O) cyc_n++;
            DAT_I = 32'hA0 + 32'(i);
            step();
            chk("rd_vld", CPU_DAT_VALID_O, 1);
            chk("rd_dat", CPU_DAT_O, 32'hA0 + 32'(i));
        end
        ACK_I = 1'b0;
        chk("rd_cyc_end", CYC_O, 0);
        chk("rd_busy_end", BUSY_O, 0);
        chk("rd_ncyc", cyc_n, beats);
        step();
        chk("rd_vld_end", CPU_DAT_VALID_O, 0);
    endtask

    initial begin
        nRST = 1'b0; WRITE_I = 0; READ_I = 0; ADR_I = 0; LEN_I = 0; SEL_I = 0;
        CPU_DAT_I = 0; DAT_I = 0; ACK_I = 0;
        #12;
        chk("rst_cyc", CYC_O, 0);
        chk("rst_stb", STB_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_we", WE_O, 0);
        chk("rst_adr", ADR_O, 0);
        chk("rst_err", ERR_O, 0);
        chk("rst_vld", CPU_DAT_VALID_O, 0);
        nRST = 1'b1;

        // Reset in the middle of a 4-beat read
        ADR_I = 32'h200; LEN_I = 5'd4; SEL_I = 4'hF; READ_I = 1'b1;
        step();
        READ_I = 1'b0;
        chk("mr_cyc", CYC_O, 1);
        chk("mr_adr", ADR_O, 32'h200);
        ACK_I = 1'b1; DAT_I = 32'h55;
        step();
        ACK_I = 1'b0;
        chk("mr_vld", CPU_DAT_VALID_O, 1);
        chk("mr_dat", CPU_DAT_O, 32'h55);
        chk("mr_adr1", ADR_O, 32'h204);
        #2; nRST = 1'b0; #1;
        chk("mr_rst_cyc", CYC_O, 0);
        chk("mr_rst_stb", STB_O, 0);
        chk("mr_rst_busy", BUSY_O, 0);
        chk("mr_rst_adr", ADR_O, 0);
        chk("mr_rst_dat", CPU_DAT_O, 0);
        nRST = 1'b1;
        read_burst(32'h1000, 5'd8, 8);

        // Single write, ACK after two wait cycles, then readback
        ADR_I = 32'h3100_0000; LEN_I = 5'd1; SEL_I = 4'hF; CPU_DAT_I = 32'd12; WRITE_I = 1'b1;
        step();
        WRITE_I = 1'b0;
        chk("sw_adr", ADR_O, 32'h3100_0000);
        chk("sw_dat", DAT_O, 32'd12);
        chk("sw_we", WE_O, 1);
        chk("sw_sel", SEL_O, 4'hF);
        step();
        step();
        chk("sw_wait_cyc", CYC_O, 1);
        ACK_I = 1'b1; #1;
        chk("sw_dack", CPU_DAT_ACK_O, 0);
        step();
        ACK_I = 1'b0;
        chk("sw_busy_end", BUSY_O, 0);
        chk("sw_we_end", WE_O, 0);
        chk("sw_vld", CPU_DAT_VALID_O, 0);
        step();
        READ_I = 1'b1;
        step();
        READ_I = 1'b0;
        chk("rb_we", WE_O, 0);
        chk("rb_adr", ADR_O, 32'h3100_0000);
        ACK_I = 1'b1; DAT_I = 32'd12;
        step();
        ACK_I = 1'b0;
        chk("rb_vld", CPU_DAT_VALID_O, 1);
        chk("rb_dat", CPU_DAT_O, 32'd12);
        step();
        chk("rb_vld_once", CPU_DAT_VALID_O, 0);
        chk("rb_hold", CPU_DAT_O, 32'd12);

        // 4-beat zero-wait read
        read_burst(32'h100, 5'd4, 4);

        // 3-beat write, one wait per beat; CPU presents the next word ahead
        ADR_I = 32'h400; LEN_I = 5'd3; CPU_DAT_I = 32'h11; WRITE_I = 1'b1;
        step();
        WRITE_I = 1'b0;
        CPU_DAT_I = 32'h22;
        acks = 0;
        for (int b = 0; b < 3; b++) begin
            chk("bw_dat", DAT_O, 32'h11 * (b + 1));
            chk("bw_adr", ADR_O, 32'h400 + 32'(4 * b));
            chk("bw_we", WE_O, 1);
            step();
            ACK_I = 1'b1; #1;
            chk("bw_dack", CPU_DAT_ACK_O, (b != 2));
            if (CPU_DAT_ACK_O) acks++;
            step();
            ACK_I = 1'b0;
            if (b == 0) CPU_DAT_I = 32'h33;
        end
        chk("bw_cyc_end", CYC_O, 0);
        chk("bw_nacks", acks, 2);
        step();

        // Length boundaries and address wrap
        read_burst(32'h600, 5'd0, 1);
        read_burst(32'h700, 5'd31, 16);
        read_burst(32'hFFFF_FFFC, 5'd2, 2);

        // Both request lines high: ignored
        ADR_I = 32'h800; LEN_I = 5'd1; READ_I = 1'b1; WRITE_I = 1'b1;
        step();
        READ_I = 1'b0; WRITE_I = 1'b0;
        chk("both_cyc", CYC_O, 0);
        chk("both_busy", BUSY_O, 0);
        step();
        chk("both_cyc2", CYC_O, 0);

        // Request while busy: ignored, not queued
        ADR_I = 32'h500; LEN_I = 5'd2; READ_I = 1'b1;
        step();
        ADR_I = 32'h900;
        step();
        READ_I = 1'b0;
        chk("ib_adr", ADR_O, 32'h500);
        chk("ib_busy", BUSY_O, 1);
        ACK_I = 1'b1; DAT_I = 32'h1;
        step();
        step();
        ACK_I = 1'b0;
        chk("ib_cyc_end", CYC_O, 0);
        step();
        step();
        chk("ib_no_queue", CYC_O, 0);

        // ACK never arrives
        ADR_I = 32'hA00; LEN_I = 5'd1; READ_I = 1'b1;
        step();
        READ_I = 1'b0;
`ifdef WBM_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_wait_cyc", CYC_O, 1);
            chk("to_wait_err", ERR_O, 0);
        end
        step();
        chk("to_cyc", CYC_O, 0);
        chk("to_busy", BUSY_O, 0);
        chk("to_err", ERR_O, 1);
        chk("to_vld", CPU_DAT_VALID_O, 0);
        step();
        chk("to_err_once", ERR_O, 0);
`else
        repeat (100) step();
        chk("hang_cyc", CYC_O, 1);
        chk("hang_busy", BUSY_O, 1);
        chk("hang_err", ERR_O, 0);
        nRST = 1'b0; #1;
        chk("hang_rst_cyc", CYC_O, 0);
        nRST = 1'b1;
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
